uart_btn_cmd_decoder: RTL



---
 rtl/uart_btn_cmd_decoder_pkg.sv | 73 +++++++
 rtl/uart_btn_cmd_decoder_if.sv | 23 ++
 rtl/uart_btn_cmd_decoder_cmd_cycle_timer.sv | 35 +++
 rtl/uart_btn_cmd_decoder.sv | 124 ++++++++++++
 4 files changed

// File: rtl/uart_btn_cmd_decoder_pkg.sv
// rtl/uart_btn_cmd_decoder_pkg.sv - shared constants, types and decode helpers for the UART button decoder
package uart_btn_cmd_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BTN = 2'd1,
        ST_PULSE    = 2'd2
    } state_e;

    localparam logic [1:0] TGT_WATCH     = 2'd0;
    localparam logic [1:0] TGT_STOPWATCH = 2'd1;
    localparam logic [1:0] TGT_SR04      = 2'd2;
    localparam logic [1:0] TGT_DHT11     = 2'd3;

    localparam logic [7:0] ASCII_W  = 8'h57;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_U  = 8'h55;
    localparam logic [7:0] ASCII_H  = 8'h48;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_D  = 8'h44;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } target_dec_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] onehot;
    } button_dec_t;

    function automatic logic [7:0] fold_upper(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A) begin
            return b - 8'h20;
        end
        return b;
    endfunction

    function automatic target_dec_t decode_target(input logic [7:0] b);
        target_dec_t t;
        t = '{valid: 1'b1, idx: TGT_WATCH};
        case (b)
            ASCII_W: t.idx = TGT_WATCH;
            ASCII_S: t.idx = TGT_STOPWATCH;
            ASCII_U: t.idx = TGT_SR04;
            ASCII_H: t.idx = TGT_DHT11;
            default: t.valid = 1'b0;
        endcase
        return t;
    endfunction

    function automatic button_dec_t decode_button(input logic [7:0] b);
        button_dec_t d;
        d = '{valid: 1'b1, onehot: 4'b0000};
        case (b)
            ASCII_R: d.onehot = 4'b0001;
            ASCII_L: d.onehot = 4'b0010;
            ASCII_U: d.onehot = 4'b0100;
            ASCII_D: d.onehot = 4'b1000;
            default: d.valid  = 1'b0;
        endcase
        return d;
    endfunction

    // A one-cycle terminal count still needs a one-bit register
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_btn_cmd_decoder_if.sv
// rtl/uart_btn_cmd_decoder_if.sv - receive-byte input and button/status outputs of the decoder
interface uart_btn_cmd_decoder_if;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic [3:0] o_btn_uart_watch;
    logic [3:0] o_btn_uart_stopwatch;
    logic [3:0] o_btn_uart_sr04;
    logic [3:0] o_btn_uart_dht11;
    logic       o_cmd_err;
    logic       o_busy;

    modport master (
        output i_rx_data, i_rx_done,
        input  o_btn_uart_watch, o_btn_uart_stopwatch, o_btn_uart_sr04, o_btn_uart_dht11,
        input  o_cmd_err, o_busy
    );

    modport slave (
        input  i_rx_data, i_rx_done,
        output o_btn_uart_watch, o_btn_uart_stopwatch, o_btn_uart_sr04, o_btn_uart_dht11,
        output o_cmd_err, o_busy
    );
endinterface

// File: rtl/uart_btn_cmd_decoder_cmd_cycle_timer.sv
// rtl/uart_btn_cmd_decoder_cmd_cycle_timer.sv - clearable saturating counter with terminal-count flag
module cmd_cycle_timer #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned TERMINAL = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != TERM)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == TERM);
endmodule

// File: rtl/uart_btn_cmd_decoder.sv
// rtl/uart_btn_cmd_decoder.sv - two-byte ASCII command decoder driving timed button pulses on four mode buses
module uart_btn_cmd_decoder
    import uart_btn_cmd_decoder_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES   = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_btn_cmd_decoder_if.slave  io
);
    state_e      state_q, state_d;
    logic [1:0]  target_q, target_d;
    logic [15:0] bus_q, bus_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic        tmo_tc;
    logic        pls_tc;
    logic [7:0]  rx_byte;
    logic        rx_live;
    target_dec_t tdec;
    button_dec_t bdec;

    // The error flop adds a cycle, so the timer flags one count early
    cmd_cycle_timer #(
        .WIDTH    (cnt_width(TIMEOUT_CYCLES)),
        .TERMINAL (TIMEOUT_CYCLES - 2)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (state_q != ST_WAIT_BTN),
        .i_en  (state_q == ST_WAIT_BTN),
        .o_tc  (tmo_tc)
    );

    cmd_cycle_timer #(
        .WIDTH    (cnt_width(PULSE_CYCLES)),
        .TERMINAL (PULSE_CYCLES - 1)
    ) u_pulse (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (state_q != ST_PULSE),
        .i_en  (state_q == ST_PULSE),
        .o_tc  (pls_tc)
    );

    always_comb begin
        rx_byte  = fold_upper(io.i_rx_data);
        tdec     = decode_target(rx_byte);
        bdec     = decode_button(rx_byte);
        rx_live  = io.i_rx_done && (rx_byte != ASCII_CR) && (rx_byte != ASCII_LF);

        state_d  = state_q;
        target_d = target_q;
        bus_d    = bus_q;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_live) begin
                    if (tdec.valid) begin
                        target_d = tdec.idx;
                        state_d  = ST_WAIT_BTN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_BTN: begin
                if (rx_live) begin
                    if (bdec.valid) begin
                        bus_d   = {12'b0, bdec.onehot} << {target_q, 2'b00};
                        state_d = ST_PULSE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tmo_tc) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (rx_live) begin
                    err_d = 1'b1;
                end
                if (pls_tc) begin
                    bus_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                bus_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            target_q <= TGT_WATCH;
            bus_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            bus_q    <= bus_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign io.o_btn_uart_watch     = bus_q[3:0];
    assign io.o_btn_uart_stopwatch = bus_q[7:4];
    assign io.o_btn_uart_sr04      = bus_q[11:8];
    assign io.o_btn_uart_dht11     = bus_q[15:12];
    assign io.o_cmd_err            = err_q;
    assign io.o_busy               = busy_q;
endmodule
